// File: rtl/fifo_rd_word_packer.sv
// Read-side FIFO consumer: pops bytes (1-cycle read latency), packs BYTES of them
// into a word and offers it on a valid/ready port, with flush of partial words.
module fifo_rd_word_packer #(
  parameter int unsigned BYTES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk_read,
  input  logic                 rst,
  input  logic [7:0]           fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [BYTES*8-1:0]   out_data,
  output logic [3:0]           out_nbytes,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned WORD_W = BYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {S_REQ, S_CAP, S_OUT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   r_out_data;
  logic [3:0]          r_out_nbytes;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_word_cnt;
  logic                w_last;
  logic                w_hs;
  logic                w_pop;
  logic                w_flush_go;

  assign w_last = (r_idx == LAST_IDX);
  assign w_hs   = r_out_valid & out_ready;

  // State register
  always_ff @(posedge clk_read) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_REQ: begin
        if (w_pop)           w_next = S_CAP;
        else if (w_flush_go) w_next = S_OUT;
      end
      S_CAP: begin
        if (w_last)     w_next = S_OUT;
        else if (w_pop) w_next = S_CAP;
        else            w_next = S_REQ;
      end
      S_OUT: begin
        if (w_hs) w_next = w_pop ? S_CAP : S_REQ;
      end
      default: w_next = S_REQ;
    endcase
  end

  // Mealy outputs: pop request and flush strobe, never popping an empty FIFO
  always_comb begin
    w_pop      = 1'b0;
    w_flush_go = 1'b0;
    if (!rst) begin
      case (r_state)
        S_REQ: begin
          w_pop      = !fifo_empty;
          w_flush_go = fifo_empty & flush & (r_idx != '0);
        end
        S_CAP:   w_pop = !w_last & !fifo_empty;
        S_OUT:   w_pop = w_hs & !fifo_empty;
        default: w_pop = 1'b0;
      endcase
    end
  end

  assign fifo_rd_en = w_pop;

  // Word being assembled with the incoming byte dropped into slot idx
  always_comb begin
    w_word = r_word;
    for (int k = 0; k < int'(BYTES); k++) begin
      if (r_idx == IDX_W'(k)) w_word[8*k +: 8] = fifo_data;
    end
  end

  // Datapath; r_word keeps unfilled slots at zero so a flushed word is zero-padded
  always_ff @(posedge clk_read) begin
    if (rst) begin
      r_idx        <= '0;
      r_word       <= '0;
      r_out_data   <= '0;
      r_out_nbytes <= '0;
      r_out_valid  <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_flush_go) begin
            r_out_data   <= r_word;
            r_out_nbytes <= 4'(r_idx);
            r_out_valid  <= 1'b1;
            r_idx        <= '0;
            r_word       <= '0;
          end
        end
        S_CAP: begin
          if (w_last) begin
            r_out_data   <= w_word;
            r_out_nbytes <= 4'(BYTES);
            r_out_valid  <= 1'b1;
            r_idx        <= '0;
            r_word       <= '0;
          end else begin
            r_word <= w_word;
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        S_OUT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_word_cnt  <= r_word_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_nbytes = r_out_nbytes;
  assign out_valid  = r_out_valid;
  assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// Directed bench for fifo_rd_word_packer (BYTES=2) with a small behavioural FIFO model.
module tb_fifo_rd_word_packer;

  logic        clk_read = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_nbytes;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] word_cnt;

  fifo_rd_word_packer #(.BYTES(2), .CNT_W(16)) dut (
    .clk_read   (clk_read),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_cnt   (word_cnt)
  );

  always #5 clk_read = ~clk_read;

  int total = 0;
  int bad   = 0;

  // FIFO model: data appears on fifo_data the cycle after a pop
  logic [7:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  logic fifo_clr = 1'b0;
  int viol = 0;
  int rst_pop = 0;
  assign fifo_empty = (rp == wp);

  always @(posedge clk_read) begin
    if (fifo_rd_en && fifo_empty) viol <= viol + 1;
    if (fifo_rd_en && rst) rst_pop <= rst_pop + 1;
    if (fifo_clr) rp <= wp;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  // Log of accepted words
  logic [15:0] wlog [0:63];
  logic [3:0]  wnb  [0:63];
  int          wcyc [0:63];
  int nw = 0;
  int cyc = 0;
  always @(posedge clk_read) begin
    cyc <= cyc + 1;
    if (!rst && out_valid && out_ready) begin
      wlog[nw] <= out_data;
      wnb[nw]  <= out_nbytes;
      wcyc[nw] <= cyc;
      nw <= nw + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_read);
  endtask

  function automatic logic [7:0] bv(input int k);
    return 8'(16 + k);
  endfunction

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b0; flush = 1'b0;
    push(8'h77);
    tick(2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data); end
    total++; if (out_nbytes !== 4'd0) begin bad++; $display("FAIL reset_nbytes got=%0d exp=0", out_nbytes); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    fifo_clr = 1'b1;
    tick(1);
    fifo_clr = 1'b0; rst = 1'b0; out_ready = 1'b1;
    tick(1);
  endtask

  task automatic test_stream;
    int base = nw;
    int rd = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 20 && nw < base + 2; i++) tick(1);
    total++; if (nw !== base + 2) begin bad++; $display("FAIL stream_words got=%0d exp=%0d", nw - base, 2); end
    total++; if (wlog[base] !== 16'h2211) begin bad++; $display("FAIL stream_w0 got=%h exp=2211", wlog[base]); end
    total++; if (wlog[base+1] !== 16'h4433) begin bad++; $display("FAIL stream_w1 got=%h exp=4433", wlog[base+1]); end
    total++; if (wnb[base] !== 4'd2 || wnb[base+1] !== 4'd2) begin bad++; $display("FAIL stream_nbytes got=%0d,%0d exp=2,2", wnb[base], wnb[base+1]); end
    total++; if (word_cnt !== 16'd2) begin bad++; $display("FAIL stream_cnt got=%0d exp=2", word_cnt); end
    repeat (5) begin tick(1); if (fifo_rd_en) rd++; end
    total++; if (rd !== 0) begin bad++; $display("FAIL stream_idle_rd got=%0d exp=0", rd); end
  endtask

  task automatic test_backpressure;
    int base = nw;
    int hold_err = 0;
    out_ready = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick(1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 16'h6655) begin bad++; $display("FAIL bp_data got=%h exp=6655", out_data); end
    repeat (10) begin
      tick(1);
      if (out_valid !== 1'b1 || out_data !== 16'h6655 || out_nbytes !== 4'd2 || fifo_rd_en !== 1'b0) hold_err++;
    end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    total++; if (nw !== base) begin bad++; $display("FAIL bp_no_accept got=%0d exp=0", nw - base); end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && nw < base + 2; i++) tick(1);
    total++; if (wlog[base] !== 16'h6655 || wlog[base+1] !== 16'h8877) begin bad++; $display("FAIL bp_words got=%h,%h exp=6655,8877", wlog[base], wlog[base+1]); end
    total++; if (word_cnt !== 16'd4) begin bad++; $display("FAIL bp_cnt got=%0d exp=4", word_cnt); end
  endtask

  task automatic test_gap;
    int base = nw;
    push(8'hAA);
    tick(5);
    total++; if (nw !== base || out_valid !== 1'b0) begin bad++; $display("FAIL gap_early got=%0d/%b exp=0/0", nw - base, out_valid); end
    push(8'hBB);
    for (int i = 0; i < 10 && nw < base + 1; i++) tick(1);
    total++; if (wlog[base] !== 16'hBBAA) begin bad++; $display("FAIL gap_word got=%h exp=BBAA", wlog[base]); end
    tick(4);
    total++; if (nw !== base + 1) begin bad++; $display("FAIL gap_count got=%0d exp=1", nw - base); end
    total++; if (word_cnt !== 16'd5) begin bad++; $display("FAIL gap_cnt got=%0d exp=5", word_cnt); end
  endtask

  task automatic test_flush;
    int base = nw;
    push(8'h5A);
    tick(4);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_pre got=%b exp=0", out_valid); end
    flush = 1'b1;
    tick(1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h005A) begin bad++; $display("FAIL flush_word got=%b/%h exp=1/005A", out_valid, out_data); end
    total++; if (out_nbytes !== 4'd1) begin bad++; $display("FAIL flush_nbytes got=%0d exp=1", out_nbytes); end
    flush = 1'b0;
    tick(1);
    flush = 1'b1;
    tick(5);
    flush = 1'b0;
    total++; if (nw !== base + 1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_idx0 got=%0d/%b exp=1/0", nw - base, out_valid); end
    push(8'h01); push(8'h02);
    for (int i = 0; i < 10 && nw < base + 2; i++) tick(1);
    total++; if (wlog[base+1] !== 16'h0201 || wnb[base+1] !== 4'd2) begin bad++; $display("FAIL flush_after got=%h/%0d exp=0201/2", wlog[base+1], wnb[base+1]); end
    total++; if (word_cnt !== 16'd7) begin bad++; $display("FAIL flush_cnt got=%0d exp=7", word_cnt); end
  endtask

  task automatic test_reset_mid;
    int base;
    push(8'hC1); push(8'hC2);
    tick(2);
    rst = 1'b1;
    tick(1);
    total++; if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin bad++; $display("FAIL rmid_state got=%b/%0d exp=0/0", out_valid, word_cnt); end
    rst = 1'b0;
    base = nw;
    push(8'hD1); push(8'hD2);
    for (int i = 0; i < 10 && nw < base + 1; i++) tick(1);
    total++; if (nw !== base + 1 || wlog[base] !== 16'hD2D1) begin bad++; $display("FAIL rmid_word got=%h exp=D2D1", wlog[base]); end
  endtask

  task automatic test_back_to_back;
    int base;
    int data_err = 0;
    int gap_err = 0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    base = nw;
    for (int k = 0; k < 22; k++) push(bv(k));
    for (int i = 0; i < 40 && nw < base + 10; i++) tick(1);
    total++; if (nw !== base + 10) begin bad++; $display("FAIL b2b_words got=%0d exp=10", nw - base); end
    total++; if (word_cnt !== 16'd10) begin bad++; $display("FAIL b2b_cnt got=%0d exp=10", word_cnt); end
    for (int j = 0; j < 10; j++) begin
      if (wlog[base+j] !== {bv(2*j+1), bv(2*j)}) data_err++;
      if (j > 0 && (wcyc[base+j] - wcyc[base+j-1]) != 3) gap_err++;
    end
    total++; if (data_err !== 0) begin bad++; $display("FAIL b2b_data got=%0d exp=0", data_err); end
    total++; if (gap_err !== 0) begin bad++; $display("FAIL b2b_spacing got=%0d exp=0", gap_err); end
    tick(5);
  endtask

  task automatic test_protocol;
    total++; if (viol !== 0) begin bad++; $display("FAIL pop_when_empty got=%0d exp=0", viol); end
    total++; if (rst_pop !== 0) begin bad++; $display("FAIL pop_in_reset got=%0d exp=0", rst_pop); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gap();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
